// File: rtl/gelato_scoreboard.sv
// gelato_scoreboard
//   Per-warp table of destination registers with writes in flight. The warp
//   scheduler marks a register dirty when it issues an instruction, and the
//   writeback stage releases it when the result commits. The table is
//   published so the scheduler can detect full warps and RAW/WAW hazards.
//
// Ports
//   clk, rst      clock, synchronous active-high reset (wins over rdy)
//   rdy           global enable; when low, state and error flags are frozen
//   set_*         insert request (valid, warp, register)
//   rel_*         release request (valid, warp, register)
//   regs          slot contents, warp w slot s at [(w*SCOREBOARD_SIZE+s)*REG_W +: REG_W]
//   full          per-warp "no free slot"
//   count         per-warp occupancy, CNT_W bits per warp
//   err_overflow  sticky: insert dropped because the warp was full
//   err_dup       sticky: insert of a register already dirty in that warp
//   err_release   sticky: release matched no slot
//
// Register index 0 (x0) is never tracked and doubles as the "free slot" code.

module gelato_scoreboard #(
  parameter int WARP_NUM        = 4,
  parameter int SCOREBOARD_SIZE = 4,
  parameter int REG_W           = 5,
  parameter int CNT_W           = $clog2(SCOREBOARD_SIZE + 1),
  parameter int WARP_W          = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      rdy,
  input  logic                                      set_valid,
  input  logic [WARP_W-1:0]                         set_warp,
  input  logic [REG_W-1:0]                          set_reg,
  input  logic                                      rel_valid,
  input  logic [WARP_W-1:0]                         rel_warp,
  input  logic [REG_W-1:0]                          rel_reg,
  output logic [WARP_NUM*SCOREBOARD_SIZE*REG_W-1:0] regs,
  output logic [WARP_NUM-1:0]                       full,
  output logic [WARP_NUM*CNT_W-1:0]                 count,
  output logic                                      err_overflow,
  output logic                                      err_dup,
  output logic                                      err_release
);

  logic [REG_W-1:0] slot_q  [WARP_NUM][SCOREBOARD_SIZE];
  logic [REG_W-1:0] slot_nx [WARP_NUM][SCOREBOARD_SIZE];
  logic [CNT_W-1:0] cnt_q   [WARP_NUM];
  logic [CNT_W-1:0] cnt_nx  [WARP_NUM];
  logic [WARP_NUM-1:0] full_q;
  logic ovf_q, dup_q, relerr_q;
  logic ovf_nx, dup_nx, relerr_nx;
  logic rel_hit, set_dup, set_done;

  // Release is applied to the table first; the set then sees the
  // post-release contents, so a same-cycle release+set of one register is a
  // legal re-insert and a release on a full warp makes room for the set.
  always_comb begin
    slot_nx   = slot_q;
    cnt_nx    = cnt_q;
    ovf_nx    = ovf_q;
    dup_nx    = dup_q;
    relerr_nx = relerr_q;
    rel_hit   = 1'b0;
    set_dup   = 1'b0;
    set_done  = 1'b0;
    for (int w = 0; w < WARP_NUM; w++) begin
      rel_hit = 1'b0;
      if (rel_valid && (rel_reg != '0) && (rel_warp == WARP_W'(w))) begin
        for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
          if (!rel_hit && (slot_nx[w][s] == rel_reg)) begin
            slot_nx[w][s] = '0;
            rel_hit       = 1'b1;
          end
        end
        if (rel_hit) cnt_nx[w] = cnt_nx[w] - CNT_W'(1);
        else         relerr_nx = 1'b1;
      end

      set_dup  = 1'b0;
      set_done = 1'b0;
      if (set_valid && (set_reg != '0) && (set_warp == WARP_W'(w))) begin
        for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
          if (slot_nx[w][s] == set_reg) set_dup = 1'b1;
        end
        if (set_dup) begin
          dup_nx = 1'b1;
        end else begin
          for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
            if (!set_done && (slot_nx[w][s] == '0)) begin
              slot_nx[w][s] = set_reg;
              set_done      = 1'b1;
            end
          end
          if (set_done) cnt_nx[w] = cnt_nx[w] + CNT_W'(1);
          else          ovf_nx    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WARP_NUM; w++) begin
        cnt_q[w] <= '0;
        for (int s = 0; s < SCOREBOARD_SIZE; s++) slot_q[w][s] <= '0;
      end
      full_q   <= '0;
      ovf_q    <= 1'b0;
      dup_q    <= 1'b0;
      relerr_q <= 1'b0;
    end else if (rdy) begin
      slot_q <= slot_nx;
      cnt_q  <= cnt_nx;
      for (int w = 0; w < WARP_NUM; w++)
        full_q[w] <= (cnt_nx[w] == CNT_W'(SCOREBOARD_SIZE));
      ovf_q    <= ovf_nx;
      dup_q    <= dup_nx;
      relerr_q <= relerr_nx;
    end
  end

  always_comb begin
    regs  = '0;
    count = '0;
    for (int w = 0; w < WARP_NUM; w++) begin
      count[w*CNT_W +: CNT_W] = cnt_q[w];
      for (int s = 0; s < SCOREBOARD_SIZE; s++)
        regs[(w*SCOREBOARD_SIZE+s)*REG_W +: REG_W] = slot_q[w][s];
    end
  end

  assign full         = full_q;
  assign err_overflow = ovf_q;
  assign err_dup      = dup_q;
  assign err_release  = relerr_q;

endmodule

// File: tb/tb_gelato_scoreboard.sv
module tb_gelato_scoreboard;
  localparam int WN = 4;
  localparam int SS = 4;
  localparam int RW = 5;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst, rdy;
  logic set_valid, rel_valid;
  logic [1:0] set_warp, rel_warp;
  logic [RW-1:0] set_reg, rel_reg;
  logic [WN*SS*RW-1:0] regs;
  logic [WN-1:0] full;
  logic [WN*CW-1:0] count;
  logic err_overflow, err_dup, err_release;

  int tests = 0;
  int fails = 0;

  // Reference model: each warp is a fixed array of slots, 0 = free.
  int m_slot [WN][SS];
  int m_ovf, m_dup, m_rel;

  gelato_scoreboard #(.WARP_NUM(WN), .SCOREBOARD_SIZE(SS), .REG_W(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .set_valid(set_valid), .set_warp(set_warp), .set_reg(set_reg),
    .rel_valid(rel_valid), .rel_warp(rel_warp), .rel_reg(rel_reg),
    .regs(regs), .full(full), .count(count),
    .err_overflow(err_overflow), .err_dup(err_dup), .err_release(err_release)
  );

  always #5 clk = ~clk;

  function automatic int occupied(int w);
    int n = 0;
    for (int s = 0; s < SS; s++) if (m_slot[w][s] != 0) n++;
    return n;
  endfunction

  function automatic int find(int w, int r);
    for (int s = 0; s < SS; s++) if (m_slot[w][s] == r) return s;
    return -1;
  endfunction

  task automatic model_step(input bit r, input bit en, input bit sv, input int sw, input int sr,
                            input bit rv, input int rw, input int rr);
    int idx;
    if (r) begin
      for (int w = 0; w < WN; w++) for (int s = 0; s < SS; s++) m_slot[w][s] = 0;
      m_ovf = 0; m_dup = 0; m_rel = 0;
    end else if (en) begin
      if (rv && rr != 0) begin
        idx = find(rw, rr);
        if (idx >= 0) m_slot[rw][idx] = 0; else m_rel = 1;
      end
      if (sv && sr != 0) begin
        if (find(sw, sr) >= 0) m_dup = 1;
        else begin
          idx = find(sw, 0);
          if (idx >= 0) m_slot[sw][idx] = sr; else m_ovf = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [WN*SS*RW-1:0] e_regs;
    logic [WN*CW-1:0]    e_cnt;
    logic [WN-1:0]       e_full;
    for (int w = 0; w < WN; w++) begin
      e_cnt[w*CW +: CW] = CW'(occupied(w));
      e_full[w] = (occupied(w) == SS);
      for (int s = 0; s < SS; s++) e_regs[(w*SS+s)*RW +: RW] = RW'(m_slot[w][s]);
    end
    tests++;
    assert (regs === e_regs) else begin fails++; $error("FAIL %s regs got %h exp %h", tag, regs, e_regs); end
    tests++;
    assert (count === e_cnt) else begin fails++; $error("FAIL %s count got %h exp %h", tag, count, e_cnt); end
    tests++;
    assert (full === e_full) else begin fails++; $error("FAIL %s full got %b exp %b", tag, full, e_full); end
    tests++;
    assert ({err_overflow, err_dup, err_release} === {m_ovf[0], m_dup[0], m_rel[0]})
      else begin fails++; $error("FAIL %s errs(ovf,dup,rel) got %b%b%b exp %0d%0d%0d", tag,
                                 err_overflow, err_dup, err_release, m_ovf, m_dup, m_rel); end
  endtask

  task automatic step(input string tag, input bit r, input bit en,
                      input bit sv, input int sw, input int sr,
                      input bit rv, input int rw, input int rr);
    @(negedge clk);
    rst = r; rdy = en;
    set_valid = sv; set_warp = 2'(sw); set_reg = RW'(sr);
    rel_valid = rv; rel_warp = 2'(rw); rel_reg = RW'(rr);
    model_step(r, en, sv, sw, sr, rv, rw, rr);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic expect_bits(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin fails++; $error("FAIL %s got %0d exp %0d", tag, got, exp); end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; set_valid = 1'b0; rel_valid = 1'b0;
    set_warp = '0; set_reg = '0; rel_warp = '0; rel_reg = '0;
    m_ovf = 0; m_dup = 0; m_rel = 0;
    for (int w = 0; w < WN; w++) for (int s = 0; s < SS; s++) m_slot[w][s] = 0;

    step("reset", 1, 1, 0, 0, 0, 0, 0, 0);
    expect_bits("reset_regs_zero", int'(regs == '0), 1);

    step("set_w1_r5", 0, 1, 1, 1, 5, 0, 0, 0);
    expect_bits("w1s0", int'(regs[(1*SS+0)*RW +: RW]), 5);
    expect_bits("count_w1", int'(count[1*CW +: CW]), 1);

    step("w2_r1", 0, 1, 1, 2, 1, 0, 0, 0);
    step("w2_r2", 0, 1, 1, 2, 2, 0, 0, 0);
    step("w2_r3", 0, 1, 1, 2, 3, 0, 0, 0);
    step("w2_r4", 0, 1, 1, 2, 4, 0, 0, 0);
    expect_bits("full_w2", int'(full[2]), 1);
    step("w2_r6_ovf", 0, 1, 1, 2, 6, 0, 0, 0);
    expect_bits("err_overflow", int'(err_overflow), 1);
    expect_bits("w2s3_kept", int'(regs[(2*SS+3)*RW +: RW]), 4);

    step("w2_rel2_set9", 0, 1, 1, 2, 9, 1, 2, 2);
    expect_bits("w2s1_is9", int'(regs[(2*SS+1)*RW +: RW]), 9);
    expect_bits("count_w2", int'(count[2*CW +: CW]), 4);

    step("w0_r7", 0, 1, 1, 0, 7, 0, 0, 0);
    step("w0_rel7_set7", 0, 1, 1, 0, 7, 1, 0, 7);
    expect_bits("err_dup_clear", int'(err_dup), 0);
    step("w0_set7_dup", 0, 1, 1, 0, 7, 0, 0, 0);
    expect_bits("err_dup_set", int'(err_dup), 1);
    expect_bits("count_w0", int'(count[0*CW +: CW]), 1);

    step("rel_w3_r8", 0, 1, 0, 0, 0, 1, 3, 8);
    expect_bits("err_release", int'(err_release), 1);
    step("reg0_ops", 0, 1, 1, 1, 0, 1, 1, 0);

    step("rdy0", 0, 0, 1, 0, 4, 0, 0, 0);
    expect_bits("rdy0_w0s1", int'(regs[(0*SS+1)*RW +: RW]), 0);

    step("mid_reset", 1, 1, 1, 2, 11, 0, 0, 0);
    expect_bits("mid_reset_flags", int'({err_overflow, err_dup, err_release}), 0);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0),
           $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gelato_scoreboard.md
Name: gelato_scoreboard

Overview:
- Per-warp table of destination registers with in-flight writes; upstream of the warp scheduler.
- Publishes the dirty-register table so the scheduler can detect full/RAW-WAW conflicts.
- Accepts set requests from the scheduler when an instruction is caught.
- Accepts release requests from the writeback stage when a result commits.

Parameters:
WARP_NUM, 4, number of warps tracked
SCOREBOARD_SIZE, 4, dirty-register slots per warp
REG_W, 5, register index width; index 0 is x0, never tracked, and also encodes "free slot"
CNT_W, $clog2(SCOREBOARD_SIZE+1), width of per-warp occupancy count

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rdy  input  1  global enable; state frozen and all requests ignored when 0
set_valid  input  1  scheduler insert request
set_warp  input  $clog2(WARP_NUM)  warp of insert
set_reg  input  REG_W  destination register to mark dirty
rel_valid  input  1  writeback release request
rel_warp  input  $clog2(WARP_NUM)  warp of release
rel_reg  input  REG_W  register whose write committed
regs  output  WARP_NUM*SCOREBOARD_SIZE*REG_W  slot contents; warp w slot s at bits [(w*SCOREBOARD_SIZE+s)*REG_W +: REG_W]
full  output  WARP_NUM  bit w = no free slot in warp w
count  output  WARP_NUM*CNT_W  occupied slots per warp
err_overflow  output  1  sticky: insert dropped because warp full
err_dup  output  1  sticky: insert of register already dirty in that warp
err_release  output  1  sticky: release matched no slot

Behaviour:
- Reset (rst=1 at posedge): all slots 0, count 0, full 0, all err flags 0. Takes priority over rdy.
- All outputs are registered. An update accepted at edge N is visible after edge N.
- rdy=0: no state change, err flags held.
- Per cycle (rdy=1), for each warp, the release is applied first, then the set, using post-release state.
- Release (rel_valid, rel_reg != 0):
  - Clears the lowest-index slot of rel_warp equal to rel_reg; count decrements.
  - No match: no change, err_release set.
  - rel_reg = 0: ignored, no error.
- Set (set_valid, set_reg != 0):
  - If set_reg is present in set_warp after the release step: no change, err_dup set.
  - Else if a free slot exists: write set_reg into the lowest-index free slot; count increments.
  - Else: drop the request, err_overflow set.
  - set_reg = 0: ignored, no error.
- Simultaneous release and set, same warp, same register: the old entry is cleared, then re-inserted in the lowest free slot. The register stays dirty, count unchanged, no err_dup.
- Simultaneous release and set, same warp, warp full: the release frees a slot and the set succeeds, no overflow.
- Different warps: both operations proceed independently in the same cycle.
- full[w] = (count[w] == SCOREBOARD_SIZE), registered alongside count.
- Warp indices are in range by construction; no bounds handling required.
- Error flags clear only on rst.

Test Plan:
- Reset, then set warp1 r5 -> next cycle regs w1 s0 = 5, count[1] = 1, other warps 0, full = 0.
- Set warp2 r1, r2, r3, r4 on four cycles, then set r6 -> full[2] = 1 after the 4th set; r6 dropped, err_overflow = 1, slots remain 1, 2, 3, 4.
- Warp2 full (1, 2, 3, 4): same cycle rel r2 + set r9 -> slots 1, 9, 3, 4, count 4, no error.
- Warp0 holds r7: same cycle rel r7 + set r7 -> slot0 = 7, count 1, err_dup = 0. Then set r7 alone -> err_dup = 1, count 1.
- rel warp3 r8 with warp3 empty -> err_release = 1, no slot change. set/rel with reg 0 -> no change, no error.
- rdy = 0 while set warp0 r4 pulses -> no change. rst mid-sequence with warp2 full -> all slots 0, flags 0 next cycle.
